// File: rtl/nvme_buffer_ram_pipe.sv
// Lane-write-enabled simple dual-port data buffer with a skid-buffered read port and a zero-fill engine.
// Define NVME_BUF_WR_BYPASS_EN to forward same-cycle written lanes to a colliding read (write-first per lane).
module nvme_buffer_ram_pipe #(
    parameter int DATA_WIDTH = 128,
    parameter int LANE_WIDTH = 32,
    parameter int ADDR_BITS  = 8,
    parameter int DEPTH      = 2**ADDR_BITS,
    localparam int LANES     = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES-1:0]      we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  re,
    output logic                  re_ready,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    input  logic                  clear_req,
    output logic                  clear_busy
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [ADDR_BITS:0]   DEPTH_W   = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    state_t                state_next;
    logic [ADDR_BITS-1:0]  clr_addr;
    logic [ADDR_BITS-1:0]  clr_addr_next;
    logic                  live;

    logic                  pending;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] skid [2];
    logic                  skid_rd;
    logic                  skid_wr;
    logic [1:0]            skid_cnt;

    logic                  accept;
    logic                  wr_ok;
    logic                  rd_in_range;
    logic                  skid_empty;
    logic                  pop;
    logic                  pop_skid;
    logic                  push;
    logic [1:0]            occ_after_pop;
    logic [DATA_WIDTH-1:0] head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_addr <= '0;
            live     <= 1'b0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
            live     <= 1'b1;
        end
    end

    // Clear engine sweeps every entry once; clear_req is not looked at while sweeping.
    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            CLEAR: begin
                clr_addr_next = clr_addr + ADDR_BITS'(1);
                if (clr_addr == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign clear_busy  = (state == CLEAR);
    assign wr_ok       = !clear_busy && ({1'b0, waddr} < DEPTH_W);
    assign rd_in_range = {1'b0, raddr} < DEPTH_W;

    always_ff @(posedge clk) begin
        if (clear_busy) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < LANES; i++) begin
                if (we[i]) begin
                    mem[waddr][i*LANE_WIDTH +: LANE_WIDTH] <= din[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[raddr];
        end
`ifdef NVME_BUF_WR_BYPASS_EN
        for (int i = 0; i < LANES; i++) begin
            if (wr_ok && we[i] && (waddr == raddr)) begin
                rd_word[i*LANE_WIDTH +: LANE_WIDTH] = din[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
`endif
    end

    // The array-stage register feeds dout directly when the skid is empty, giving 1-cycle latency.
    always_comb begin
        skid_empty    = (skid_cnt == 2'd0);
        dout_valid    = skid_empty ? pending : 1'b1;
        head          = skid_empty ? rdata : skid[skid_rd];
        dout          = dout_valid ? head : '0;
        pop           = dout_valid && dout_ready;
        pop_skid      = pop && !skid_empty;
        push          = pending && !(skid_empty && pop);
        occ_after_pop = skid_cnt + 2'(pending) - 2'(pop);
        re_ready      = live && (state == IDLE) && (occ_after_pop < 2'd2);
        accept        = re && re_ready;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rdata <= rd_word;
        end
        if (push) begin
            skid[skid_wr] <= rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            skid_cnt <= 2'd0;
            skid_rd  <= 1'b0;
            skid_wr  <= 1'b0;
        end else begin
            pending  <= accept;
            skid_cnt <= skid_cnt + 2'(push) - 2'(pop_skid);
            if (push) begin
                skid_wr <= ~skid_wr;
            end
            if (pop_skid) begin
                skid_rd <= ~skid_rd;
            end
        end
    end

endmodule

// File: tb/tb_nvme_buffer_ram_pipe.sv
// Directed self-checking bench for nvme_buffer_ram_pipe at default parameters (128-bit, 4 lanes, 256 entries).
module tb_nvme_buffer_ram_pipe;

    logic         clk;
    logic         rst_n;
    logic [3:0]   we;
    logic [7:0]   waddr;
    logic [127:0] din;
    logic         re;
    logic         re_ready;
    logic [7:0]   raddr;
    logic [127:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         clear_req;
    logic         clear_busy;

    int checks;
    int passes;

    localparam logic [127:0] PAT_FULL = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] PAT_55   = {4{32'h55555555}};
    localparam logic [127:0] PAT_AA   = {4{32'hAAAAAAAA}};
    localparam logic [127:0] PAT_MIX  = {32'h55555555, 32'h55555555, 32'hAAAAAAAA, 32'hAAAAAAAA};

    nvme_buffer_ram_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .waddr      (waddr),
        .din        (din),
        .re         (re),
        .re_ready   (re_ready),
        .raddr      (raddr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .clear_req  (clear_req),
        .clear_busy (clear_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] a, input logic [127:0] d, input logic [3:0] w);
        we    = w;
        waddr = a;
        din   = d;
        tick();
        we    = 4'b0000;
    endtask

    task automatic read_word(input logic [7:0] a, output logic [127:0] d, output bit ok);
        int n;
        ok         = 1'b0;
        d          = '0;
        re         = 1'b1;
        raddr      = a;
        dout_ready = 1'b1;
        #1;
        n = 0;
        while (!re_ready && n < 50) begin
            tick();
            n++;
        end
        if (!re_ready) begin
            re = 1'b0;
            return;
        end
        tick();
        re = 1'b0;
        n = 0;
        while (!dout_valid && n < 50) begin
            tick();
            n++;
        end
        if (dout_valid) begin
            d  = dout;
            ok = 1'b1;
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dout_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", dout_valid);
        else passes++;
        checks++;
        if (dout !== 128'h0) $display("[TB] FAIL reset_dout: got %h expected 0", dout);
        else passes++;
        checks++;
        if (re_ready !== 1'b0) $display("[TB] FAIL reset_re_ready: got %b expected 0", re_ready);
        else passes++;
        checks++;
        if (clear_busy !== 1'b0) $display("[TB] FAIL reset_clear_busy: got %b expected 0", clear_busy);
        else passes++;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (re_ready !== 1'b1) $display("[TB] FAIL post_reset_re_ready: got %b expected 1", re_ready);
        else passes++;
    endtask

    task automatic test_clear();
        int busy_cycles;
        bit ready_seen;
        logic [127:0] d;
        bit ok;
        int bad;
        write_word(8'd100, PAT_FULL, 4'b1111);
        // read and clear request land in the same cycle
        clear_req  = 1'b1;
        re         = 1'b1;
        raddr      = 8'd100;
        dout_ready = 1'b1;
        tick();
        clear_req = 1'b0;
        re        = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || dout !== PAT_FULL)
            $display("[TB] FAIL clear_preread: got valid=%b %h expected 1 %h", dout_valid, dout, PAT_FULL);
        else passes++;
        busy_cycles = 0;
        ready_seen  = 1'b0;
        while (clear_busy === 1'b1 && busy_cycles < 1000) begin
            if (re_ready !== 1'b0) ready_seen = 1'b1;
            busy_cycles++;
            if (busy_cycles == 10) begin
                we = 4'b1111; waddr = 8'd3; din = PAT_AA;
            end else begin
                we = 4'b0000;
            end
            clear_req = (busy_cycles == 50);
            tick();
        end
        we        = 4'b0000;
        clear_req = 1'b0;
        checks++;
        if (busy_cycles != 256) $display("[TB] FAIL clear_busy_cycles: got %0d expected 256", busy_cycles);
        else passes++;
        checks++;
        if (ready_seen) $display("[TB] FAIL clear_re_ready: got 1 during clear expected 0");
        else passes++;
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            read_word(8'(a), d, ok);
            checks++;
            if (!ok || d !== 128'h0) begin
                if (bad < 8) $display("[TB] FAIL clear_zero addr %0d: got ok=%b %h expected 0", a, ok, d);
                bad++;
            end else passes++;
        end
    endtask

    task automatic test_full_write();
        write_word(8'd5, PAT_FULL, 4'b1111);
        re         = 1'b1;
        raddr      = 8'd5;
        dout_ready = 1'b1;
        #1;
        checks++;
        if (re_ready !== 1'b1) $display("[TB] FAIL full_re_ready: got %b expected 1", re_ready);
        else passes++;
        tick();
        re = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || dout !== PAT_FULL)
            $display("[TB] FAIL full_read: got valid=%b %h expected 1 %h", dout_valid, dout, PAT_FULL);
        else passes++;
        tick();
        checks++;
        if (dout_valid !== 1'b0) $display("[TB] FAIL full_drained: got %b expected 0", dout_valid);
        else passes++;
    endtask

    task automatic test_partial_write();
        logic [127:0] d;
        bit ok;
        write_word(8'd7, {128{1'b1}}, 4'b0101);
        read_word(8'd7, d, ok);
        checks++;
        if (!ok || d !== 128'h00000000_FFFFFFFF_00000000_FFFFFFFF)
            $display("[TB] FAIL partial_lanes: got ok=%b %h expected 00000000ffffffff00000000ffffffff", ok, d);
        else passes++;
    endtask

    task automatic test_backpressure();
        write_word(8'd1, {4{32'hA1A1A1A1}}, 4'b1111);
        write_word(8'd2, {4{32'hA2A2A2A2}}, 4'b1111);
        write_word(8'd3, {4{32'hA3A3A3A3}}, 4'b1111);
        dout_ready = 1'b0;
        re         = 1'b1;
        raddr      = 8'd1;
        #1;
        tick();
        raddr = 8'd2;
        checks++;
        if (re_ready !== 1'b1) $display("[TB] FAIL bp_second_ready: got %b expected 1", re_ready);
        else passes++;
        tick();
        raddr = 8'd3;
        checks++;
        if (re_ready !== 1'b0) $display("[TB] FAIL bp_full_ready: got %b expected 0", re_ready);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dout_valid !== 1'b1 || dout !== {4{32'hA1A1A1A1}} || re_ready !== 1'b0)
                $display("[TB] FAIL bp_stall_%0d: got valid=%b ready=%b %h expected 1 0 a1..", i, dout_valid, re_ready, dout);
            else passes++;
        end
        dout_ready = 1'b1;
        #1;
        checks++;
        if (re_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %b expected 1", re_ready);
        else passes++;
        tick();
        re = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || dout !== {4{32'hA2A2A2A2}})
            $display("[TB] FAIL bp_order_2: got valid=%b %h expected 1 a2..", dout_valid, dout);
        else passes++;
        tick();
        checks++;
        if (dout_valid !== 1'b1 || dout !== {4{32'hA3A3A3A3}})
            $display("[TB] FAIL bp_order_3: got valid=%b %h expected 1 a3..", dout_valid, dout);
        else passes++;
        tick();
        checks++;
        if (dout_valid !== 1'b0) $display("[TB] FAIL bp_empty: got %b expected 0", dout_valid);
        else passes++;
    endtask

    task automatic test_collision();
        logic [127:0] d;
        bit ok;
        logic [127:0] exp;
        write_word(8'd9, PAT_55, 4'b1111);
        we         = 4'b0011;
        waddr      = 8'd9;
        din        = PAT_AA;
        re         = 1'b1;
        raddr      = 8'd9;
        dout_ready = 1'b1;
        tick();
        we = 4'b0000;
        re = 1'b0;
`ifdef NVME_BUF_WR_BYPASS_EN
        exp = PAT_MIX;
`else
        exp = PAT_55;
`endif
        checks++;
        if (dout_valid !== 1'b1 || dout !== exp)
            $display("[TB] FAIL collision_read: got valid=%b %h expected 1 %h", dout_valid, dout, exp);
        else passes++;
        tick();
        read_word(8'd9, d, ok);
        checks++;
        if (!ok || d !== PAT_MIX)
            $display("[TB] FAIL collision_after: got ok=%b %h expected %h", ok, d, PAT_MIX);
        else passes++;
    endtask

    task automatic test_back_to_back();
        dout_ready = 1'b1;
        re         = 1'b1;
        raddr      = 8'd5;
        #1;
        tick();
        raddr = 8'd7;
        checks++;
        if (dout_valid !== 1'b1 || dout !== PAT_FULL || re_ready !== 1'b1)
            $display("[TB] FAIL b2b_0: got valid=%b ready=%b %h expected 1 1 %h", dout_valid, re_ready, dout, PAT_FULL);
        else passes++;
        tick();
        raddr = 8'd9;
        checks++;
        if (dout_valid !== 1'b1 || dout !== 128'h00000000_FFFFFFFF_00000000_FFFFFFFF || re_ready !== 1'b1)
            $display("[TB] FAIL b2b_1: got valid=%b ready=%b %h expected 1 1 partial", dout_valid, re_ready, dout);
        else passes++;
        tick();
        re = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || dout !== PAT_MIX)
            $display("[TB] FAIL b2b_2: got valid=%b %h expected 1 %h", dout_valid, dout, PAT_MIX);
        else passes++;
        tick();
        checks++;
        if (dout_valid !== 1'b0) $display("[TB] FAIL b2b_empty: got %b expected 0", dout_valid);
        else passes++;
    endtask

    task automatic test_reset_mid_clear();
        bit busy_seen;
        bit ready_low;
        dout_ready = 1'b0;
        re         = 1'b1;
        raddr      = 8'd5;
        #1;
        tick();
        re        = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (99) tick();
        checks++;
        if (clear_busy !== 1'b1 || dout_valid !== 1'b1 || dout !== PAT_FULL)
            $display("[TB] FAIL midclear_hold: got busy=%b valid=%b %h expected 1 1 %h", clear_busy, dout_valid, dout, PAT_FULL);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || clear_busy !== 1'b0)
            $display("[TB] FAIL midclear_reset: got valid=%b busy=%b expected 0 0", dout_valid, clear_busy);
        else passes++;
        tick();
        rst_n = 1'b1;
        tick();
        busy_seen = 1'b0;
        ready_low = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (clear_busy !== 1'b0) busy_seen = 1'b1;
            if (re_ready !== 1'b1) ready_low = 1'b1;
        end
        checks++;
        if (busy_seen || ready_low)
            $display("[TB] FAIL midclear_release: got busy_seen=%b ready_low=%b expected 0 0", busy_seen, ready_low);
        else passes++;
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        rst_n      = 1'b0;
        we         = 4'b0000;
        waddr      = 8'd0;
        din        = '0;
        re         = 1'b0;
        raddr      = 8'd0;
        dout_ready = 1'b0;
        clear_req  = 1'b0;
        test_reset();
        test_clear();
        test_full_write();
        test_partial_write();
        test_backpressure();
        test_collision();
        test_back_to_back();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
